// File: rtl/rv_pkg.sv
// Shared RV32I encoder definitions: opcode-class constants, NOP word and format enumeration.
package rv_pkg;

  localparam logic [4:0] CLS_LOAD   = 5'b00000;
  localparam logic [4:0] CLS_STORE  = 5'b01000;
  localparam logic [4:0] CLS_BRANCH = 5'b11000;
  localparam logic [4:0] CLS_JALR   = 5'b11001;
  localparam logic [4:0] CLS_JAL    = 5'b11011;
  localparam logic [4:0] CLS_LUI    = 5'b01101;
  localparam logic [4:0] CLS_AUIPC  = 5'b00101;
  localparam logic [4:0] CLS_OP_IMM = 5'b00100;
  localparam logic [4:0] CLS_OP     = 5'b01100;
  localparam logic [4:0] CLS_SYSTEM = 5'b11100;

  localparam logic [31:0] NOP_IR    = 32'h0000_0013;
  localparam int unsigned PAYLOAD_W = 33;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  function automatic fmt_e class_fmt(input logic [4:0] cls);
    fmt_e f;
    case (cls)
      CLS_OP:                                     f = FMT_R;
      CLS_LOAD, CLS_JALR, CLS_OP_IMM, CLS_SYSTEM: f = FMT_I;
      CLS_STORE:                                  f = FMT_S;
      CLS_BRANCH:                                 f = FMT_B;
      CLS_LUI, CLS_AUIPC:                         f = FMT_U;
      CLS_JAL:                                    f = FMT_J;
      default:                                    f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Request/result bundle between an instruction producer (master) and the encoder (slave).
interface insn_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_class;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic        out_err;
  logic [15:0] enc_count;

  modport master (
    output in_valid, in_class, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_ir, out_err, enc_count
  );

  modport slave (
    input  in_valid, in_class, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_ir, out_err, enc_count
  );
endinterface

// File: rtl/insn_enc_skid.sv
// Two-entry in-order result buffer; ready/valid are registered so out_ready never reaches in_ready.
module insn_enc_skid #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push_valid,
  output logic         o_push_ready,
  input  logic [W-1:0] i_push_data,
  output logic         o_pop_valid,
  input  logic         i_pop_ready,
  output logic [W-1:0] o_pop_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       r_state;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push_valid & r_in_ready;
  assign w_pop  = r_out_valid & i_pop_ready;

  // Occupancy FSM; r_head is always the oldest entry, r_tail only holds data in FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= {W{1'b0}};
      r_tail      <= {W{1'b0}};
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head      <= i_push_data;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= i_push_data;
          end else if (w_push) begin
            r_tail     <= i_push_data;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head     <= r_tail;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_push_ready = r_in_ready;
  assign o_pop_valid  = r_out_valid;
  assign o_pop_data   = r_head;

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder with one-cycle latency into a two-entry result buffer.
// Define RV_ENC_RANGE_CHECK_EN to flag immediates that do not fit their format.
module insn_encoder
  import rv_pkg::*;
(
  input logic           clk,
  input logic           rst,
  insn_encoder_if.slave bus
);

  fmt_e                 w_fmt;
  logic [6:0]           w_opc;
  logic                 w_shift;
  logic [31:0]          w_ir;
  logic                 w_fmt_err;
  logic                 w_err;
  logic [31:0]          w_imm;
  logic [PAYLOAD_W-1:0] w_head;
  logic                 w_out_valid;
  logic                 w_in_ready;
  logic [15:0]          r_enc_count;

  assign w_imm   = bus.in_imm;
  assign w_opc   = {bus.in_class, 2'b11};
  assign w_fmt   = class_fmt(bus.in_class);
  // SLLI/SRLI/SRAI are funct3 001/101: funct7 replaces imm[11:5]
  assign w_shift = (bus.in_class == CLS_OP_IMM) && (bus.in_funct3[1:0] == 2'b01);

  // Field placement per format; unused fields stay zero.
  always_comb begin
    w_ir      = 32'h0000_0000;
    w_fmt_err = 1'b0;
    case (w_fmt)
      FMT_R: w_ir = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, w_opc};
      FMT_I: begin
        if (w_shift) begin
          w_ir = {bus.in_funct7, w_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, w_opc};
        end else begin
          w_ir = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, w_opc};
        end
      end
      FMT_S: w_ir = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], w_opc};
      FMT_B: w_ir = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     w_imm[4:1], w_imm[11], w_opc};
      FMT_U: w_ir = {w_imm[31:12], bus.in_rd, w_opc};
      FMT_J: w_ir = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, w_opc};
      default: begin
        w_ir      = NOP_IR;
        w_fmt_err = 1'b1;
      end
    endcase
  end

`ifdef RV_ENC_RANGE_CHECK_EN
  logic w_range_err;

  // Immediate must be the sign extension of the bits the format keeps.
  always_comb begin
    w_range_err = 1'b0;
    case (w_fmt)
      FMT_I: begin
        if (w_shift) begin
          w_range_err = |w_imm[31:5];
        end else begin
          w_range_err = (w_imm[31:11] != {21{w_imm[11]}});
        end
      end
      FMT_S:   w_range_err = (w_imm[31:11] != {21{w_imm[11]}});
      FMT_B:   w_range_err = (w_imm[31:12] != {20{w_imm[12]}}) | w_imm[0];
      FMT_J:   w_range_err = (w_imm[31:20] != {12{w_imm[20]}}) | w_imm[0];
      FMT_U:   w_range_err = |w_imm[11:0];
      default: w_range_err = 1'b0;
    endcase
  end

  assign w_err = w_fmt_err | w_range_err;
`else
  assign w_err = w_fmt_err;
`endif

  insn_enc_skid #(.W(PAYLOAD_W)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (bus.in_valid),
    .o_push_ready (w_in_ready),
    .i_push_data  ({w_err, w_ir}),
    .o_pop_valid  (w_out_valid),
    .i_pop_ready  (bus.out_ready),
    .o_pop_data   (w_head)
  );

  // Completed output handshakes, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_count <= 16'h0000;
    end else if (w_out_valid && bus.out_ready) begin
      r_enc_count <= r_enc_count + 16'h0001;
    end else begin
      r_enc_count <= r_enc_count;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_err   = w_head[32];
  assign bus.out_ir    = w_head[31:0];
  assign bus.enc_count = r_enc_count;

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 in_valid  input  1  request carries an instruction to encode.
REQ-004 in_ready  output  1  encoder can accept the request this cycle.
REQ-005 in_class  input  5  instruction class, equal to opcode[6:2] (LOAD 00000, STORE 01000, BRANCH 11000, JALR 11001, JAL 11011, LUI 01101, AUIPC 00101, OP_IMM 00100, OP 01100, SYSTEM 11100).
REQ-006 in_funct3  input  3  funct3 field.
REQ-007 in_funct7  input  7  funct7 field, used by OP and by OP_IMM shifts.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 in_imm  input  32  immediate as a signed/raw 32-bit value, unscrambled.
REQ-010 out_valid  output  1  out_ir holds an encoded instruction.
REQ-011 out_ready  input  1  consumer accepts out_ir this cycle.
REQ-012 out_ir  output  32  encoded RV32I instruction word.
REQ-013 out_err  output  1  encoding error flag, qualified by out_valid.
REQ-014 enc_count  output  16  number of completed output handshakes.

Function
REQ-015 Input handshake SHALL complete when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-016 Latency SHALL be one cycle: an accepted request is visible on out_ir/out_valid the cycle after acceptance, when the buffer was empty.
REQ-017 Results SHALL pass through a 2-entry in-order buffer with states EMPTY, ONE, FULL; in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL (registered, no combinational path from out_ready).
REQ-018 Simultaneous push and pop in state ONE SHALL stay in ONE with the new entry queued behind the departing one; push without pop advances state, pop without push retreats.
REQ-019 opcode bits IR[6:0] SHALL be {in_class, 2'b11}.
REQ-020 R-type (OP): IR = {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-021 I-type (LOAD, JALR, OP_IMM, SYSTEM): IR[31:20] = imm[11:0]; OP_IMM with funct3 001 or 101 SHALL instead use IR[31:25]=funct7, IR[24:20]=imm[4:0].
REQ-022 S-type (STORE): IR[31:25]=imm[11:5], IR[11:7]=imm[4:0], rs2/rs1/funct3 in standard positions.
REQ-023 B-type (BRANCH): IR[31]=imm[12], IR[30:25]=imm[10:5], IR[11:8]=imm[4:1], IR[7]=imm[11].
REQ-024 U-type (LUI, AUIPC): IR[31:12]=imm[31:12], IR[11:7]=rd.
REQ-025 J-type (JAL): IR[31]=imm[20], IR[30:21]=imm[10:1], IR[20]=imm[11], IR[19:12]=imm[19:12], IR[11:7]=rd.
REQ-026 Fields not used by a format SHALL be zero in out_ir.
REQ-027 Unlisted in_class values SHALL produce out_ir = 32'h00000013 (NOP) with out_err = 1.
REQ-028 enc_count SHALL increment by 1 per output handshake, wrapping 16'hFFFF -> 16'h0000.

Reset
REQ-029 rst SHALL force buffer to EMPTY, out_valid=0, out_err=0, out_ir=32'h0, enc_count=0, in_ready=1 on the following cycle; in-flight entries SHALL be discarded, including mid-handshake.

Configuration
REQ-030 With RV_ENC_RANGE_CHECK_EN defined, out_err SHALL also be 1 when in_imm is not representable: I/S not sign-extension of imm[11:0]; B not sign-extension of imm[12:0] or imm[0]=1; J not sign-extension of imm[20:0] or imm[0]=1; U imm[11:0] non-zero; shift imm[31:5] non-zero; out_ir still encoded from truncated bits.
REQ-031 Without RV_ENC_RANGE_CHECK_EN, out_err SHALL be 1 only per REQ-027 and no range logic SHALL be synthesized.

Structure
REQ-032 Shared package rv_pkg SHALL hold the 5-bit class constants, the NOP constant, and the format enumeration (R, I, S, B, U, J).
REQ-033 The 2-entry buffer SHALL be a sub-module insn_enc_skid, parameterised on payload width (33 bits: err + IR).

Verification
REQ-034 OP_IMM funct3=000 rd=1 rs1=0 imm=5 -> out_ir 32'h00500093, out_err 0, one cycle later.
REQ-035 STORE funct3=010 rs1=1 rs2=2 imm=8 -> 32'h0020A423; JAL rd=1 imm=8 -> 32'h008000EF; LUI rd=5 imm=32'h12345000 -> 32'h123452B7.
REQ-036 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 third cycle; release out_ready -> outputs in order, third accepted, enc_count=3.
REQ-037 OP_IMM imm=2048 -> out_ir 32'h80000093; out_err 1 with RV_ENC_RANGE_CHECK_EN, 0 without.
REQ-038 in_class=5'b11111 -> out_ir 32'h00000013, out_err 1; rst asserted while FULL -> next cycle out_valid 0, in_ready 1, enc_count 0.
